// File: rtl/bound_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bound_flash_pkg
// Description : Shared types, constants and helpers for the bound-flasher
//               LED bar sequencer (state codes, level limits, default table).
// Revision    : 1.0 - initial release
// ============================================================================
package bound_flash_pkg;

    localparam int LEVEL_MAX     = 16;
    localparam int LEVEL_W       = 5;
    localparam int LED_W         = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_UP   = 2'b01;
    localparam state_t ST_DOWN = 2'b10;
    localparam state_t ST_DONE = 2'b11;

    // Entry 0 sits in the least significant slice: {6,0,11,5,16,0,0,0}
    localparam logic [DEFAULT_DEPTH*LEVEL_W-1:0] DEFAULT_TABLE = {
        5'd0, 5'd0, 5'd0, 5'd16, 5'd5, 5'd11, 5'd0, 5'd6
    };

    // Default target for a table slot; slots beyond the default list are 0
    function automatic logic [LEVEL_W-1:0] default_level(input int idx);
        if (idx < DEFAULT_DEPTH) begin
            return DEFAULT_TABLE[idx*LEVEL_W +: LEVEL_W];
        end
        return '0;
    endfunction

    // Host values above the bar length are clipped to a full bar
    function automatic logic [LEVEL_W-1:0] sat_level(input logic [LEVEL_W-1:0] d);
        return (d > LEVEL_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bound_flash_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : bound_flash_sequencer_if
// Description : Host config / control / LED bundle of the sequencer.
//               master = host side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bound_flash_sequencer_if #(
    parameter int NSEG = 8
);
    localparam int AW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int LW = AW + 1;

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [4:0]    cfg_data;
    logic [LW-1:0] cfg_len;
    logic          start;
    logic          flick;
    logic [15:0]   led;
    logic [4:0]    level;
    logic [AW-1:0] seg_idx;
    logic          busy;
    logic          done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_len, start, flick,
        input  led, level, seg_idx, busy, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_len, start, flick,
        output led, level, seg_idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/bound_flash_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : bound_flash_prescaler
// Description : Modulo-DIV step counter with synchronous clear and enable.
//               o_step is high in the last count of each DIV-cycle window.
// Revision    : 1.0 - initial release
// ============================================================================
module bound_flash_prescaler #(
    parameter int DIV = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_step
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_TERM = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..DIV-1 while enabled; clear wins over counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= (r_cnt == C_TERM) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_step = i_enable && (r_cnt == C_TERM);

endmodule
`default_nettype wire

// File: rtl/bound_flash_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bound_flash_sequencer
// Description : Steps a 0..16 LED level through a host-loaded table of
//               segment targets, paced by a prescaler, with flick rewind.
//               Holds the target table, the FSM and the thermometer decode.
// Revision    : 1.0 - initial release
// ============================================================================
module bound_flash_sequencer
    import bound_flash_pkg::*;
#(
    parameter int NSEG    = 8,
    parameter int DIV     = 4,
    parameter int FLICK_A = 0,
    parameter int FLICK_B = 6
) (
    input  wire logic               clk,
    input  wire logic               reset,
    bound_flash_sequencer_if.slave  bus
);
    localparam int AW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] C_LEN_RST = LW'((NSEG < 6) ? NSEG : 6);

    state_t             r_state;
    state_t             w_state_next;
    logic [LEVEL_W-1:0] r_level;
    logic [AW-1:0]      r_seg;
    logic [LW-1:0]      r_len;
    logic [LEVEL_W-1:0] r_table [NSEG];

    logic               w_busy;
    logic               w_step;
    logic               w_launch;
    logic               w_last;
    logic               w_flick_acc;
    logic               w_seg_done;
    logic               w_prs_clear;
    logic [LW-1:0]      w_len_m1;
    logic [LW-1:0]      w_len_in;
    logic [AW-1:0]      w_seg_next;
    logic [LEVEL_W-1:0] w_target;
    logic [LEVEL_W-1:0] w_next_target;
    logic [LEVEL_W-1:0] w_level_step;
    logic [LEVEL_W-1:0] w_level_inc;
    logic [LED_W:0]     w_led_full;

    assign w_busy        = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign w_launch      = (r_state == ST_IDLE) && (bus.start || bus.flick);
    assign w_len_m1      = r_len - LW'(1);
    assign w_last        = (w_len_m1 == LW'(r_seg));
    assign w_seg_next    = r_seg + AW'(1);
    assign w_target      = r_table[r_seg];
    assign w_next_target = r_table[w_seg_next];
    assign w_level_inc   = (r_level >= LEVEL_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX)
                                                            : r_level + LEVEL_W'(1);
    assign w_len_in      = (bus.cfg_len == '0)          ? LW'(1) :
                           (bus.cfg_len > LW'(NSEG))    ? LW'(NSEG) : bus.cfg_len;

    assign w_flick_acc   = (r_state == ST_DOWN) && bus.flick && w_step && !w_last &&
                           ((r_level == LEVEL_W'(FLICK_A)) || (r_level == LEVEL_W'(FLICK_B)));
    assign w_seg_done    = w_step && (w_level_step == w_target);

    // Prescaler only runs while busy; it restarts from zero after a rewind
    assign w_prs_clear   = !w_busy || w_flick_acc;

    bound_flash_prescaler #(
        .DIV      (DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_prs_clear),
        .i_enable (w_busy),
        .o_step   (w_step)
    );

    // One step toward the segment target; moving toward it in either direction
    // keeps a rewind that lands above an UP target from stalling
    always_comb begin
        w_level_step = r_level;
        if (r_level < w_target) begin
            w_level_step = r_level + LEVEL_W'(1);
        end else if (r_level > w_target) begin
            w_level_step = r_level - LEVEL_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: launch, rewind, segment hand-over and completion
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_next = (r_table[0] != '0) ? ST_UP : ST_DONE;
                end
            end
            ST_UP, ST_DOWN: begin
                if (w_flick_acc) begin
                    w_state_next = ST_UP;
                end else if (w_seg_done) begin
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end else if (w_next_target > w_level_step) begin
                        w_state_next = ST_UP;
                    end else if (w_next_target < w_level_step) begin
                        w_state_next = ST_DOWN;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: status flags and thermometer decode of the registered level
    always_comb begin
        w_led_full  = ((LED_W+1)'(1) << r_level) - (LED_W+1)'(1);
        bus.led     = w_led_full[LED_W-1:0];
        bus.level   = r_level;
        bus.seg_idx = r_seg;
        bus.busy    = w_busy;
        bus.done    = (r_state == ST_DONE);
    end

    // Level, segment index and latched pattern length
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            r_seg   <= '0;
            r_len   <= C_LEN_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_level <= '0;
                        r_seg   <= '0;
                        r_len   <= w_len_in;
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (w_flick_acc) begin
                        r_seg   <= (r_seg == '0) ? '0 : r_seg - AW'(1);
                        r_level <= w_level_inc;
                    end else if (w_step) begin
                        r_level <= w_level_step;
                        if (w_seg_done && !w_last) begin
                            r_seg <= w_seg_next;
                        end
                    end
                end
                default: begin
                    r_level <= '0;
                end
            endcase
        end
    end

    // Target table: host writes only while not busy, so a run sees a stable table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSEG; i++) begin
                r_table[i] <= default_level(i);
            end
        end else if (bus.cfg_we && !w_busy) begin
            r_table[bus.cfg_addr] <= sat_level(bus.cfg_data);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bound_flash_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bound_flash_sequencer
// Description : Directed self-checking bench; one DUT with DIV=1 and one with
//               DIV=4 share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bound_flash_sequencer;
    logic clk;
    logic reset;

    int n_checks;
    int n_errors;
    int el;
    int s;
    int dones;
    int found;
    int bad;
    int prev;
    int tgt [6];

    bound_flash_sequencer_if #(.NSEG(8)) bus1 ();
    bound_flash_sequencer_if #(.NSEG(8)) bus4 ();

    bound_flash_sequencer #(.NSEG(8), .DIV(1), .FLICK_A(0), .FLICK_B(6)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    bound_flash_sequencer #(.NSEG(8), .DIV(4), .FLICK_A(0), .FLICK_B(6)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        tgt = '{6, 0, 11, 5, 16, 0};
        bus1.cfg_we = 0; bus1.cfg_addr = 0; bus1.cfg_data = 0; bus1.cfg_len = 6;
        bus1.start = 0;  bus1.flick = 0;
        bus4.cfg_we = 0; bus4.cfg_addr = 0; bus4.cfg_data = 0; bus4.cfg_len = 6;
        bus4.start = 0;  bus4.flick = 0;
        reset = 1;
        repeat (2) @(negedge clk);

        // ---- reset state
        check("rst_level1", bus1.level, 0);
        check("rst_led1",   bus1.led, 0);
        check("rst_busy1",  bus1.busy, 0);
        check("rst_done1",  bus1.done, 0);
        check("rst_seg1",   bus1.seg_idx, 0);
        check("rst_busy4",  bus4.busy, 0);
        reset = 0;
        @(negedge clk);

        // ---- 1: default table, DIV=1
        bus1.start = 1;
        @(negedge clk);
        bus1.start = 0;
        check("t1_busy_start", bus1.busy, 1);
        check("t1_level_start", bus1.level, 0);
        el = 0; s = 0; dones = 0;
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            if (el < tgt[s]) el++;
            else if (el > tgt[s]) el--;
            if (el == tgt[s] && s < 5) s++;
            check("t1_level", bus1.level, el);
            check("t1_led", bus1.led, (32'd1 << el) - 1);
            check("t1_seg", bus1.seg_idx, s);
            dones += int'(bus1.done);
        end
        check("t1_done_at_end", bus1.done, 1);
        check("t1_done_count", dones, 1);
        @(negedge clk);
        check("t1_done_after", bus1.done, 0);
        check("t1_busy_after", bus1.busy, 0);
        check("t1_level_after", bus1.level, 0);

        // ---- 3: flick at level 6 while descending in seg 3
        bus1.start = 1;
        @(negedge clk);
        bus1.start = 0;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            if (bus1.seg_idx == 3 && bus1.level == 6) found = 1;
        end
        check("t3_reach_seg3_l6", found, 1);
        bus1.flick = 1;
        @(negedge clk);
        bus1.flick = 0;
        check("t3_level", bus1.level, 7);
        check("t3_seg", bus1.seg_idx, 2);
        check("t3_busy", bus1.busy, 1);
        for (int k = 8; k <= 11; k++) begin
            @(negedge clk);
            check("t3_climb", bus1.level, k);
        end
        check("t3_seg_after_climb", bus1.seg_idx, 3);

        // ---- 4: flick held through the last segment is ignored
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            if (bus1.seg_idx == 5) found = 1;
        end
        check("t4_reach_seg5", found, 1);
        bus1.flick = 1;
        prev = int'(bus1.level);
        bad = 0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (int'(bus1.level) > prev || bus1.seg_idx != 5) bad++;
            prev = int'(bus1.level);
            if (bus1.done) found = 1;
        end
        bus1.flick = 0;
        check("t4_done_seen", found, 1);
        check("t4_no_rewind", bad, 0);
        check("t4_level_at_done", bus1.level, 0);
        @(negedge clk);
        check("t4_idle", bus1.busy, 0);

        // ---- 2: T={3,1}, len 2, DIV=4
        bus4.cfg_we = 1; bus4.cfg_addr = 0; bus4.cfg_data = 3;
        @(negedge clk);
        bus4.cfg_addr = 1; bus4.cfg_data = 1;
        @(negedge clk);
        bus4.cfg_we = 0;
        bus4.cfg_len = 2;
        bus4.start = 1;
        @(negedge clk);
        bus4.start = 0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 3)  check("t2_c3", bus4.level, 0);
            if (c == 4)  check("t2_c4", bus4.level, 1);
            if (c == 11) check("t2_c11", bus4.level, 2);
            if (c == 12) begin
                check("t2_c12_level", bus4.level, 3);
                check("t2_c12_seg", bus4.seg_idx, 1);
            end
            if (c == 16) check("t2_c16", bus4.level, 2);
            if (c == 19) begin
                check("t2_c19_level", bus4.level, 2);
                check("t2_c19_done", bus4.done, 0);
            end
            if (c == 20) begin
                check("t2_c20_level", bus4.level, 1);
                check("t2_c20_done", bus4.done, 1);
            end
            if (c == 21) begin
                check("t2_c21_done", bus4.done, 0);
                check("t2_c21_busy", bus4.busy, 0);
                check("t2_c21_level", bus4.level, 0);
            end
        end

        // ---- 5: flick in IDLE launches a pattern
        bus4.flick = 1;
        @(negedge clk);
        bus4.flick = 0;
        check("t5_busy", bus4.busy, 1);
        repeat (3) @(negedge clk);
        check("t5_level_c3", bus4.level, 0);
        @(negedge clk);
        check("t5_level_c4", bus4.level, 1);
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (!bus4.busy) found = 1;
        end
        check("t5_finishes", found, 1);

        // ---- 6: saturating write, write ignored while busy, async reset
        bus1.cfg_we = 1; bus1.cfg_addr = 0; bus1.cfg_data = 31;
        @(negedge clk);
        bus1.cfg_we = 0;
        bus1.cfg_len = 1;
        bus1.start = 1;
        @(negedge clk);
        bus1.start = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus1.cfg_we = (c == 3);
            bus1.cfg_data = 2;
            if (c == 8) check("t6_c8", bus1.level, 8);
        end
        bus1.cfg_we = 0;
        check("t6_full_level", bus1.level, 16);
        check("t6_full_led", bus1.led, 32'h0000FFFF);
        check("t6_done", bus1.done, 1);
        @(negedge clk);
        bus1.cfg_len = 6;
        bus1.start = 1;
        @(negedge clk);
        bus1.start = 0;
        repeat (4) @(negedge clk);
        check("t6_pre_reset_led", bus1.led, 32'h0000000F);
        #2 reset = 1;
        #1;
        check("t6_async_led", bus1.led, 0);
        check("t6_async_busy", bus1.busy, 0);
        check("t6_async_level", bus1.level, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        bus1.start = 1;
        @(negedge clk);
        bus1.start = 0;
        repeat (6) @(negedge clk);
        check("t6_reload_peak", bus1.level, 6);
        @(negedge clk);
        check("t6_reload_down", bus1.level, 5);
        check("t6_reload_seg", bus1.seg_idx, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
